calc_sevenseg_display: RTL

- Reads the calculator's 16-bit accumulator value and drives the board's 4-digit multiplexed seven-segment display in hexadecimal.
- Time-multiplexes the digits with a refresh prescaler.
- Double-buffers the value so a frame never shows a mix of old and new digits.
- Sits on the output side of the calculator, alongside the LED bank.

---
 rtl/calc_sevenseg_display.sv | 134 +++++++++++++
 1 files changed

// File: rtl/calc_sevenseg_display.sv
// Four-digit multiplexed hex display driver for the calculator accumulator.
// Double-buffers the value so each scanned frame shows one consistent number.
module calc_sevenseg_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1,
  parameter bit          SHOW_SIGN   = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     staged_q, staged_d;
  logic            pending_q, pending_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            frame_done_q, frame_done_d;

  logic        tick;
  logic        boundary;
  logic [3:0]  nibble;
  logic [15:0] upper;
  logic        blank;
  logic        dp_lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'b1111111;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      4'hf: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (cnt_q == CntMax);
    boundary = tick && (idx_q == 2'd3);

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    staged_d  = staged_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (load) begin
      staged_d  = value;
      pending_d = 1'b1;
    end
    // A load on the boundary cycle bypasses staging and lands in the frame directly.
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_d = value;
      end else if (pending_q) begin
        shadow_d = staged_q;
      end
    end

    upper  = shadow_q >> {idx_q, 2'b00};
    nibble = upper[3:0];
    blank  = BLANK_LZ && (idx_q != 2'd0) && (upper == 16'h0000);
    dp_lit = SHOW_SIGN && (idx_q == 2'd3) && shadow_q[15];

    an_d  = ~(4'b0001 << idx_q);
    seg_d = hex_to_seg(nibble);
    dp_d  = ~dp_lit;
    if (blank) begin
      seg_d = 7'b1111111;
      if (!dp_lit) begin
        an_d = 4'b1111;
      end
    end

    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      staged_q     <= 16'h0000;
      pending_q    <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      staged_q     <= staged_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
